// File: rtl/iow_pkg.sv
// iow_pkg: shared types and constants for the I/O Writer mechanism model.
//   - strike pattern / code / counter / column widths
//   - printed-event codes for the non-typebar magnets
//   - FSM state encoding
//   - saturating 8-bit increment used by every millisecond counter
package iow_pkg;

  localparam int IOW_NTYPE = 44;           // typebar magnets 0..43
  localparam int IOW_PW    = IOW_NTYPE + 3; // {space, tab, cr, type}
  localparam int IOW_CW    = 6;            // printed-event code width
  localparam int IOW_MSW   = 8;            // millisecond counter width
  localparam int IOW_COLW  = 7;            // print column width

  localparam logic [IOW_CW-1:0] IOW_CODE_CR    = 6'd44;
  localparam logic [IOW_CW-1:0] IOW_CODE_TAB   = 6'd45;
  localparam logic [IOW_CW-1:0] IOW_CODE_SPACE = 6'd46;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STRIKE,
    CYCLE,
    RELEASE
  } iow_state_t;

  function automatic logic [IOW_MSW-1:0] sat_inc8(input logic [IOW_MSW-1:0] v);
    return (v == {IOW_MSW{1'b1}}) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iow_prio47.sv
// iow_prio47: lowest-set-bit encoder over the 47-bit strike pattern.
// Ports:
//   pat   in  47  strike pattern {space, tab, cr, type[43:0]}
//   code  out 6   index of the lowest set bit (0 when pat is all zero)
//   multi out 1   more than one bit of pat is set
module iow_prio47
  import iow_pkg::*;
(
  input  logic [IOW_PW-1:0] pat,
  output logic [IOW_CW-1:0] code,
  output logic              multi
);

  always_comb begin
    code = '0;
    // Walk downward so the lowest set index is the last one written.
    for (int i = IOW_PW - 1; i >= 0; i--) begin
      if (pat[i]) code = IOW_CW'(i);
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi = |(pat & (pat - IOW_PW'(1)));
  end

endmodule

// File: rtl/iow_emulator.sv
// iow_emulator: model of the IBM I/O Writer typewriter mechanism as seen by
// the typewriter coupler. Debounces the strike magnets, runs the mechanical
// cycle (interlock), moves the shift basket and reports each printed
// character on a valid/ready stream.
//
// Optional build macro: IOW_COLUMN_TRACK_EN adds the MARGIN parameter, the
// col output and the print column tracking.
//
// Ports:
//   CLOCK      in   1   system clock
//   rst        in   1   synchronous active-high reset
//   tick_ms    in   1   one-cycle pulse every millisecond
//   mag_type   in   44  typebar magnets
//   mag_cr     in   1   carriage return magnet
//   mag_shift  in   1   shift magnet (level)
//   mag_tab    in   1   tab magnet
//   mag_space  in   1   space magnet
//   ilk        out  1   mechanical cycle in progress
//   shift_up   out  1   shift basket up
//   out_valid  out  1   printed event valid
//   out_ready  in   1   consumer accepts
//   out_code   out  6   0..43 typebar, 44 CR, 45 TAB, 46 SPACE
//   out_upper  out  1   shift_up at the strike
//   err_multi  out  1   one-cycle pulse: several strike magnets settled together
//   overrun    out  1   sticky: an unaccepted event was replaced
//   col        out  7   print column (IOW_COLUMN_TRACK_EN only)
//
// state   | meaning
// IDLE    | no strike magnet energised
// SETTLE  | pattern present, waiting for it to hold SETTLE_MS
// STRIKE  | one cycle: emit the event, close the interlock
// CYCLE   | interlock closed for the cycle length
// RELEASE | cycle done, waiting for every strike magnet to drop
module iow_emulator
  import iow_pkg::*;
#(
  parameter int SETTLE_MS = 2,
  parameter int CHAR_MS   = 40,
  parameter int SPACE_MS  = 30,
  parameter int CR_MS     = 200,
  parameter int SHIFT_MS  = 25
`ifdef IOW_COLUMN_TRACK_EN
  ,
  parameter int MARGIN    = 86
`endif
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 tick_ms,
  input  logic [IOW_NTYPE-1:0] mag_type,
  input  logic                 mag_cr,
  input  logic                 mag_shift,
  input  logic                 mag_tab,
  input  logic                 mag_space,
  output logic                 ilk,
  output logic                 shift_up,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IOW_CW-1:0]    out_code,
  output logic                 out_upper,
  output logic                 err_multi,
  output logic                 overrun
`ifdef IOW_COLUMN_TRACK_EN
  ,
  output logic [IOW_COLW-1:0]  col
`endif
);

  localparam logic [IOW_MSW-1:0] SETTLE_T = 8'(SETTLE_MS);
  localparam logic [IOW_MSW-1:0] CHAR_T   = 8'(CHAR_MS);
  localparam logic [IOW_MSW-1:0] SPACE_T  = 8'(SPACE_MS);
  localparam logic [IOW_MSW-1:0] CR_T     = 8'(CR_MS);
  localparam logic [IOW_MSW-1:0] SHIFT_T  = 8'(SHIFT_MS);

  iow_state_t          state;
  logic [IOW_PW-1:0]   p_q;
  logic [IOW_PW-1:0]   p_lat;
  logic [IOW_MSW-1:0]  cnt;
  logic [IOW_MSW-1:0]  cyc_len;
  logic [IOW_MSW-1:0]  cyc_sel;
  logic [IOW_CW-1:0]   sel_code;
  logic                sel_multi;

  logic                sh_q;
  logic [IOW_MSW-1:0]  scnt;

  iow_prio47 u_prio (
    .pat   (p_lat),
    .code  (sel_code),
    .multi (sel_multi)
  );

  always_comb begin
    cyc_sel = CHAR_T;
    if (sel_code == IOW_CODE_CR) begin
      cyc_sel = CR_T;
    end else if (sel_code == IOW_CODE_TAB || sel_code == IOW_CODE_SPACE) begin
      cyc_sel = SPACE_T;
    end
  end

`ifdef IOW_COLUMN_TRACK_EN
  localparam logic [IOW_COLW-1:0] COL_MAX = 7'(MARGIN - 1);

  logic [IOW_COLW-1:0] col_nxt;
  logic [IOW_COLW:0]   tab_stop;

  always_comb begin
    // One bit wider so a tab from column 120+ cannot wrap before the cap.
    tab_stop = {1'b0, col[IOW_COLW-1:3], 3'b000} + 8'd8;
    col_nxt  = col;
    if (sel_code == IOW_CODE_CR) begin
      col_nxt = '0;
    end else if (sel_code == IOW_CODE_TAB) begin
      col_nxt = (tab_stop > {1'b0, COL_MAX}) ? COL_MAX : tab_stop[IOW_COLW-1:0];
    end else if (col < COL_MAX) begin
      col_nxt = col + 7'd1;
    end
  end
`endif

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state     <= IDLE;
      p_q       <= '0;
      p_lat     <= '0;
      cnt       <= '0;
      cyc_len   <= '0;
      ilk       <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_upper <= 1'b0;
      err_multi <= 1'b0;
      overrun   <= 1'b0;
`ifdef IOW_COLUMN_TRACK_EN
      col       <= '0;
`endif
    end else begin
      p_q       <= {mag_space, mag_tab, mag_cr, mag_type};
      err_multi <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (p_q != '0) begin
            p_lat <= p_q;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (p_q == '0) begin
            state <= IDLE;
          end else if (p_q != p_lat) begin
            p_lat <= p_q;
            cnt   <= '0;
          end else if (cnt >= SETTLE_T) begin
            state <= STRIKE;
          end else if (tick_ms) begin
            cnt <= sat_inc8(cnt);
          end
        end
        STRIKE: begin
          out_code  <= sel_code;
          out_upper <= shift_up;
          err_multi <= sel_multi;
          // The new event overwrites an unaccepted one; the loss is remembered.
          if (out_valid && !out_ready) overrun <= 1'b1;
          out_valid <= 1'b1;
          ilk       <= 1'b1;
          cyc_len   <= cyc_sel;
          cnt       <= '0;
`ifdef IOW_COLUMN_TRACK_EN
          col       <= col_nxt;
`endif
          state     <= CYCLE;
        end
        CYCLE: begin
          if (cnt >= cyc_len) begin
            ilk   <= 1'b0;
            state <= RELEASE;
          end else if (tick_ms) begin
            cnt <= sat_inc8(cnt);
          end
        end
        RELEASE: begin
          if (p_q == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift basket: travels only after the magnet has disagreed with the
  // basket for SHIFT_MS consecutive ticks; agreeing again restarts the count.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      sh_q     <= 1'b0;
      shift_up <= 1'b0;
      scnt     <= '0;
    end else begin
      sh_q <= mag_shift;
      if (sh_q == shift_up) begin
        scnt <= '0;
      end else if (scnt >= SHIFT_T) begin
        shift_up <= sh_q;
        scnt     <= '0;
      end else if (tick_ms) begin
        scnt <= sat_inc8(scnt);
      end
    end
  end

endmodule

// File: tb/tb_iow_emulator.sv
module tb_iow_emulator;
  import iow_pkg::*;

  localparam int TICK_DIV = 5;

  logic        CLOCK = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic [43:0] mag_type = '0;
  logic        mag_cr = 1'b0, mag_shift = 1'b0, mag_tab = 1'b0, mag_space = 1'b0;
  logic        out_ready = 1'b1;
  logic        ilk, shift_up, out_valid, out_upper, err_multi, overrun;
  logic [5:0]  out_code;
`ifdef IOW_COLUMN_TRACK_EN
  logic [6:0]  col;
`endif

  iow_emulator dut (
    .CLOCK     (CLOCK),
    .rst       (rst),
    .tick_ms   (tick_ms),
    .mag_type  (mag_type),
    .mag_cr    (mag_cr),
    .mag_shift (mag_shift),
    .mag_tab   (mag_tab),
    .mag_space (mag_space),
    .ilk       (ilk),
    .shift_up  (shift_up),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_upper (out_upper),
    .err_multi (err_multi),
    .overrun   (overrun)
`ifdef IOW_COLUMN_TRACK_EN
    ,
    .col       (col)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int tdiv = 0;
  int ilk_ticks = 0;
  int shift_ticks = 0;
  int err_pulses = 0;
  int ev_code[$];
  int ev_upper[$];

  // Tick source and passive monitor, both on the falling edge.
  always @(negedge CLOCK) begin
    if (tdiv == TICK_DIV - 1) begin
      tdiv = 0;
      tick_ms = 1'b1;
    end else begin
      tdiv++;
      tick_ms = 1'b0;
    end
    if (ilk && tick_ms) ilk_ticks++;
    if ((mag_shift != shift_up) && tick_ms) shift_ticks++;
    if (err_multi) err_pulses++;
    if (out_valid && out_ready) begin
      ev_code.push_back(int'(out_code));
      ev_upper.push_back(int'(out_upper));
    end
  end

  typedef struct {
    logic [46:0] pat;
    logic        shift;
    int          code;
    int          upper;
    int          multi;
    int          ilk_ms;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic set_pat(input logic [46:0] p);
    {mag_space, mag_tab, mag_cr, mag_type} = p;
  endtask

  task automatic wait_ilk(input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (ilk !== v && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, 48'(ilk === v), 48'd1);
  endtask

  task automatic wait_shift(input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (shift_up !== v && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, 48'(shift_up === v), 48'd1);
  endtask

  // One full mechanical cycle for pattern p, then all magnets released.
  task automatic strike(input logic [46:0] p, input string name);
    set_pat(p);
    wait_ilk(1'b1, 100, {name, "_ilk_rise"});
    wait_ilk(1'b0, 1200, {name, "_ilk_fall"});
    set_pat('0);
    cyc(5);
  endtask

  function automatic int head_code();
    return (ev_code.size() > 0) ? ev_code[0] : -1;
  endfunction

  initial begin
    int lat;
    int sticky_before;

    vecs[0] = '{47'd1 << 0,  1'b0, 0,  0, 0, 40};
    vecs[1] = '{47'd1 << 43, 1'b0, 43, 0, 0, 40};
    vecs[2] = '{47'd1 << 45, 1'b0, 45, 0, 0, 30};
    vecs[3] = '{47'd1 << 46, 1'b0, 46, 0, 0, 30};
    vecs[4] = '{(47'd1 << 4) | (47'd1 << 6), 1'b0, 4, 0, 1, 40};
    vecs[5] = '{47'd1 << 9,  1'b1, 9,  1, 0, 40};
    vecs[6] = '{(47'd1 << 44) | (47'd1 << 10), 1'b1, 10, 1, 1, 40};
    vecs[7] = '{(47'd1 << 46) | (47'd1 << 45), 1'b0, 45, 0, 1, 30};

    // Reset: three cycles with rst high.
    rst = 1'b1;
    cyc(3);
    chk("rst_ilk", 48'(ilk), 48'd0);
    chk("rst_shift_up", 48'(shift_up), 48'd0);
    chk("rst_out_valid", 48'(out_valid), 48'd0);
    chk("rst_out_code", 48'(out_code), 48'd0);
    chk("rst_out_upper", 48'(out_upper), 48'd0);
    chk("rst_err_multi", 48'(err_multi), 48'd0);
    chk("rst_overrun", 48'(overrun), 48'd0);
`ifdef IOW_COLUMN_TRACK_EN
    chk("rst_col", 48'(col), 48'd0);
`endif
    rst = 1'b0;
    cyc(2);

    // Typebar 2 held 60 ms: one event after settling, 40 ms interlock.
    ev_code.delete(); ev_upper.delete(); ilk_ticks = 0;
    mag_type[2] = 1'b1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      cyc(1);
      lat++;
    end
    chk("held_settle_latency_ok", 48'(lat >= 8 && lat <= 16), 48'd1);
    cyc(60 * TICK_DIV - lat);
    chk("held_ilk_low_after_cycle", 48'(ilk), 48'd0);
    mag_type[2] = 1'b0;
    cyc(5);
    chk("held_event_count", 48'(ev_code.size()), 48'd1);
    chk("held_code", 48'(head_code()), 48'd2);
    chk("held_upper", 48'((ev_upper.size() > 0) ? ev_upper[0] : -1), 48'd0);
    chk("held_ilk_ms", 48'(ilk_ticks), 48'd40);

    // Table of single strikes.
    for (int i = 0; i < 8; i++) begin
      mag_shift = vecs[i].shift;
      wait_shift(vecs[i].shift, 400, $sformatf("vec%0d_shift_ready", i));
      ev_code.delete(); ev_upper.delete(); err_pulses = 0; ilk_ticks = 0;
      strike(vecs[i].pat, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_events", i), 48'(ev_code.size()), 48'd1);
      chk($sformatf("vec%0d_code", i), 48'(head_code()), 48'(vecs[i].code));
      chk($sformatf("vec%0d_upper", i),
          48'((ev_upper.size() > 0) ? ev_upper[0] : -1), 48'(vecs[i].upper));
      chk($sformatf("vec%0d_err_multi", i), 48'(err_pulses), 48'(vecs[i].multi));
      chk($sformatf("vec%0d_ilk_ms", i), 48'(ilk_ticks), 48'(vecs[i].ilk_ms));
    end

    // Shift basket travel time both ways.
    mag_shift = 1'b0;
    wait_shift(1'b0, 400, "shift_settle_down");
    cyc(3);
    shift_ticks = 0;
    mag_shift = 1'b1;
    wait_shift(1'b1, 400, "shift_rise");
    chk("shift_rise_ms_ok", 48'(shift_ticks >= 25 && shift_ticks <= 26), 48'd1);
    cyc(3);
    shift_ticks = 0;
    mag_shift = 1'b0;
    cyc(10 * TICK_DIV);
    chk("shift_still_up_at_10ms", 48'(shift_up), 48'd1);
    mag_shift = 1'b1;          // reversal restarts the count
    cyc(3);
    mag_shift = 1'b0;
    shift_ticks = 0;
    cyc(20 * TICK_DIV);
    chk("shift_up_after_restart_20ms", 48'(shift_up), 48'd1);
    wait_shift(1'b0, 400, "shift_fall");
    chk("shift_fall_total_ms_ok", 48'(shift_ticks >= 25 && shift_ticks <= 26), 48'd1);

    // CR: 1 ms glitch is ignored, 5 ms hold strikes with a 200 ms cycle.
    ev_code.delete(); ev_upper.delete(); ilk_ticks = 0;
    mag_cr = 1'b1;
    cyc(TICK_DIV);
    mag_cr = 1'b0;
    cyc(10 * TICK_DIV);
    chk("cr_glitch_no_event", 48'(ev_code.size()), 48'd0);
    chk("cr_glitch_no_ilk", 48'(ilk_ticks), 48'd0);
    mag_cr = 1'b1;
    cyc(5 * TICK_DIV);
    mag_cr = 1'b0;
    wait_ilk(1'b0, 1200, "cr_ilk_fall");
    cyc(3);
    chk("cr_events", 48'(ev_code.size()), 48'd1);
    chk("cr_code", 48'(head_code()), 48'd44);
    chk("cr_ilk_ms", 48'(ilk_ticks), 48'd200);

    // Overrun: two strikes with the consumer stalled.
    ev_code.delete(); ev_upper.delete();
    out_ready = 1'b0;
    strike(47'd1 << 3, "ovr_first");
    chk("ovr_valid_held", 48'(out_valid), 48'd1);
    chk("ovr_code_first", 48'(out_code), 48'd3);
    sticky_before = int'(overrun);
    chk("ovr_clear_before_second", 48'(sticky_before), 48'd0);
    strike(47'd1 << 5, "ovr_second");
    chk("ovr_set", 48'(overrun), 48'd1);
    chk("ovr_code_second", 48'(out_code), 48'd5);
    out_ready = 1'b1;
    cyc(2);
    chk("ovr_drained_valid", 48'(out_valid), 48'd0);
    chk("ovr_drained_events", 48'(ev_code.size()), 48'd1);
    chk("ovr_drained_code", 48'(head_code()), 48'd5);
    chk("ovr_sticky", 48'(overrun), 48'd1);

    // Reset in the middle of a cycle.
    out_ready = 1'b0;
    mag_type[7] = 1'b1;
    wait_ilk(1'b1, 100, "midrst_ilk_rise");
    cyc(20);
    rst = 1'b1;
    cyc(1);
    chk("midrst_ilk", 48'(ilk), 48'd0);
    chk("midrst_valid", 48'(out_valid), 48'd0);
    chk("midrst_overrun", 48'(overrun), 48'd0);
    mag_type[7] = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(3);

`ifdef IOW_COLUMN_TRACK_EN
    strike(47'd1 << 1, "col_c1");
    chk("col_after_c1", 48'(col), 48'd1);
    strike(47'd1 << 1, "col_c2");
    chk("col_after_c2", 48'(col), 48'd2);
    strike(47'd1 << 1, "col_c3");
    chk("col_after_c3", 48'(col), 48'd3);
    strike(47'd1 << 45, "col_tab");
    chk("col_after_tab", 48'(col), 48'd8);
    strike(47'd1 << 44, "col_cr");
    chk("col_after_cr", 48'(col), 48'd0);
    ev_code.delete(); ev_upper.delete();
    for (int i = 0; i < 90; i++) strike(47'd1 << 1, "col_run");
    chk("col_margin_hold", 48'(col), 48'd85);
    chk("col_margin_events", 48'(ev_code.size()), 48'd90);
    strike(47'd1 << 45, "col_tab_at_margin");
    chk("col_tab_capped", 48'(col), 48'd85);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
